// File: rtl/mul_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mul_product_accumulator
// Purpose  : Sums groups of signed products from the tree multiplier into a
//            wider accumulator. A group ends on a product flagged prod_last.
//            Each finished sum is held in a 1-deep valid/ready output buffer
//            together with the group's term count and a sticky signed
//            overflow flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1       rising-edge clock
//   reset       in   1       synchronous, active-low
//   en          in   1       global enable; 0 freezes all state
//   prod_valid  in   1       prod_in / prod_last valid this cycle
//   prod_in     in   PROD_W  signed product
//   prod_last   in   1       final term of the current group
//   in_ready    out  1       a product is accepted this cycle if valid
//   out_valid   out  1       output buffer holds a finished group
//   out_ready   in   1       downstream takes the result this cycle
//   acc_out     out  ACC_W   signed group sum
//   term_count  out  CNT_W   products in the group (saturating)
//   overflow    out  1       signed overflow seen anywhere in the group
// ============================================================================
module mul_product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     prod_valid,
  input  logic signed [PROD_W-1:0] prod_in,
  input  logic                     prod_last,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic        [CNT_W-1:0]  term_count,
  output logic                     overflow
);

  // Running group state
  logic signed [ACC_W-1:0] r_acc;
  logic        [CNT_W-1:0] r_cnt;
  logic                    r_ovf;

  // Output buffer
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_acc_out;
  logic        [CNT_W-1:0] r_term_count;
  logic                    r_overflow;

  // Handshake and datapath
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_take;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_ovf_step;
  logic        [CNT_W-1:0] w_cnt_next;

  // The buffer can take a new result when empty or being drained this cycle.
  assign w_in_ready = en & (~r_out_valid | out_ready);
  assign w_accept   = w_in_ready & prod_valid;
  assign w_take     = en & r_out_valid & out_ready;

  // Sign extension; the equal-width case needs no replication term.
  generate
    if (ACC_W > PROD_W) begin : g_ext_wide
      assign w_ext = {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    end else begin : g_ext_equal
      assign w_ext = prod_in;
    end
  endgenerate

  assign w_sum = r_acc + w_ext;

  // Overflow: operands agree in sign but the wrapped sum does not.
  assign w_ovf_step = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  // Saturating increment of the term counter.
  assign w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_acc_out    <= '0;
      r_term_count <= '0;
      r_overflow   <= 1'b0;
    end else if (en) begin
      if (w_accept) begin
        if (prod_last) begin
          // Close the group: publish the result and restart accumulation.
          r_acc_out    <= w_sum;
          r_term_count <= w_cnt_next;
          r_overflow   <= r_ovf | w_ovf_step;
          r_acc        <= '0;
          r_cnt        <= '0;
          r_ovf        <= 1'b0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= w_cnt_next;
          r_ovf <= r_ovf | w_ovf_step;
        end
      end

      // A new result loading in the same cycle as a take keeps valid high.
      if (w_accept && prod_last) begin
        r_out_valid <= 1'b1;
      end else if (w_take) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign acc_out    = r_acc_out;
  assign term_count = r_term_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mul_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_product_accumulator
// Purpose  : Directed self-checking bench. A default build (ACC_W=72) and an
//            ACC_W=64 build share all inputs so the overflow case can be
//            observed on both widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               en;
  logic               prod_valid;
  logic signed [63:0] prod_in;
  logic               prod_last;
  logic               out_ready;

  logic               in_ready;
  logic               out_valid;
  logic signed [71:0] acc_out;
  logic        [7:0]  term_count;
  logic               overflow;

  logic               in_ready64;
  logic               out_valid64;
  logic signed [63:0] acc_out64;
  logic        [7:0]  term_count64;
  logic               overflow64;

  int n_tests = 0;
  int n_fail  = 0;

  mul_product_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .prod_valid (prod_valid),
    .prod_in    (prod_in),
    .prod_last  (prod_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .term_count (term_count),
    .overflow   (overflow)
  );

  mul_product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) dut64 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .prod_valid (prod_valid),
    .prod_in    (prod_in),
    .prod_last  (prod_last),
    .in_ready   (in_ready64),
    .out_valid  (out_valid64),
    .out_ready  (out_ready),
    .acc_out    (acc_out64),
    .term_count (term_count64),
    .overflow   (overflow64)
  );

  task automatic check(input string tag, input logic signed [71:0] obs,
                       input logic signed [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [63:0] p, input logic l);
    prod_valid = v;
    prod_in    = p;
    prod_last  = l;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; out_ready = 1'b0;
    drive(1'b0, 64'sd0, 1'b0);

    // ---- Reset ----
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_term_count", term_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b1; en = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // ---- Group -35, 6, 48 ----
    out_ready = 1'b1;
    drive(1'b1, -64'sd35, 1'b0); tick();
    drive(1'b1,  64'sd6,  1'b0); tick();
    check("g1_not_valid_early", out_valid, 0);
    drive(1'b1,  64'sd48, 1'b1); tick();
    drive(1'b0,  64'sd0,  1'b0);
    check("g1_valid", out_valid, 1);
    check("g1_acc", acc_out, 19);
    check("g1_cnt", term_count, 3);
    check("g1_ovf", overflow, 0);
    tick();
    check("g1_drained", out_valid, 0);

    // ---- Group -45, 0, 10 with back-pressure ----
    out_ready = 1'b0;
    drive(1'b1, -64'sd45, 1'b0); tick();
    drive(1'b1,  64'sd0,  1'b0); tick();
    drive(1'b1,  64'sd10, 1'b1); tick();
    drive(1'b1, 64'sd100, 1'b1);   // pending product while stalled
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_acc", acc_out, -35);
      check("bp_cnt", term_count, 3);
      tick();
    end
    check("bp_acc_after_hold", acc_out, -35);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    tick();
    drive(1'b0, 64'sd0, 1'b0);
    check("bp_new_valid", out_valid, 1);
    check("bp_new_acc", acc_out, 100);
    check("bp_new_cnt", term_count, 1);
    tick();
    check("bp_drained", out_valid, 0);

    // ---- Back-to-back single-term groups ----
    drive(1'b1, 64'sd24, 1'b1); tick();
    check("b2b_v0", out_valid, 1);
    check("b2b_a0", acc_out, 24);
    check("b2b_c0", term_count, 1);
    drive(1'b1, 64'sd7, 1'b1); tick();
    check("b2b_v1", out_valid, 1);
    check("b2b_a1", acc_out, 7);
    check("b2b_c1", term_count, 1);
    drive(1'b1, -64'sd1, 1'b1); tick();
    check("b2b_v2", out_valid, 1);
    check("b2b_a2", acc_out, -1);
    check("b2b_c2", term_count, 1);
    drive(1'b0, 64'sd0, 1'b0); tick();
    check("b2b_drained", out_valid, 0);

    // ---- Overflow: two x (2^63-1) ----
    drive(1'b1, 64'sh7FFF_FFFF_FFFF_FFFF, 1'b0); tick();
    drive(1'b1, 64'sh7FFF_FFFF_FFFF_FFFF, 1'b1); tick();
    check("ovf64_valid", out_valid64, 1);
    check("ovf64_acc", acc_out64, -2);
    check("ovf64_flag", overflow64, 1);
    check("ovf64_cnt", term_count64, 2);
    check("ovf72_acc", acc_out, 72'sh00_FFFF_FFFF_FFFF_FFFE);
    check("ovf72_flag", overflow, 0);
    drive(1'b1, 64'sd5, 1'b1); tick();
    drive(1'b0, 64'sd0, 1'b0);
    check("ovf_next64_acc", acc_out64, 5);
    check("ovf_next64_flag", overflow64, 0);
    check("ovf_next64_cnt", term_count64, 1);
    tick();
    check("ovf_drained", out_valid, 0);

    // ---- Term counter saturation: 300 zero terms ----
    for (int i = 0; i < 299; i++) begin
      drive(1'b1, 64'sd0, 1'b0); tick();
    end
    drive(1'b1, 64'sd0, 1'b1); tick();
    drive(1'b0, 64'sd0, 1'b0);
    check("sat_cnt", term_count, 255);
    check("sat_acc", acc_out, 0);
    tick();

    // ---- Enable hold, then reset mid-group ----
    drive(1'b1, 64'sd5, 1'b0); tick();
    drive(1'b1, 64'sd5, 1'b0); tick();
    en = 1'b0;
    drive(1'b1, 64'sd99, 1'b1);
    #1;
    check("en0_in_ready", in_ready, 0);
    tick();
    drive(1'b0, 64'sd0, 1'b0);
    en = 1'b1;
    #1;
    check("en0_no_accept", out_valid, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(1'b1, 64'sd3, 1'b1); tick();
    drive(1'b0, 64'sd0, 1'b0);
    check("rst_mid_valid", out_valid, 1);
    check("rst_mid_acc", acc_out, 3);
    check("rst_mid_cnt", term_count, 1);
    check("rst_mid_ovf", overflow, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mul_product_accumulator.md
Name: mul_product_accumulator

Overview:
- Downstream consumer of the registered 32x32 signed tree multiplier.
- Takes a stream of signed 64-bit products and sums each group of terms (a group ends at `prod_last`), as in a dot product or FIR tap sum, into a wider accumulator.
- Presents each finished sum through a 1-deep valid/ready output buffer, with a per-group term count and a sticky signed-overflow flag.

Parameters:
- PROD_W, 64, width of the signed product input (multiplier result width)
- ACC_W, 72, width of the signed accumulator and result; must be >= PROD_W
- CNT_W, 8, width of the term counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low; state clears on a clk edge while reset=0
- en  input  1  global enable; 0 freezes all state
- prod_valid  input  1  prod_in/prod_last valid this cycle
- prod_in  input  PROD_W  signed product from the multiplier
- prod_last  input  1  this product is the final term of the group
- in_ready  output  1  block accepts a product this cycle
- out_valid  output  1  acc_out/term_count/overflow hold a finished group
- out_ready  input  1  downstream takes the result this cycle
- acc_out  output  ACC_W  signed sum of the group
- term_count  output  CNT_W  number of products in the group (saturating)
- overflow  output  1  signed overflow occurred anywhere in the group

Behaviour:
- Internal state: running accumulator acc (ACC_W), running count cnt (CNT_W), running sticky ovf, and the output register set.
- Reset (reset=0 at edge): acc=0, cnt=0, ovf=0, out_valid=0, acc_out=0, term_count=0, overflow=0. Reset overrides en and any in-flight group; a partial group is discarded.
- Handshakes:
  - Accept = en & prod_valid & in_ready.
  - Output take = en & out_valid & out_ready.
  - in_ready = en & (!out_valid | out_ready), combinational.
- Arithmetic:
  - prod_in is sign-extended to ACC_W; sum = acc + ext(prod_in), wrapping two's complement.
  - ovf_step = both operands have the same sign and sum has the opposite sign.
  - cnt increments by 1 per accepted term and saturates at 2^CNT_W-1.
- Accept with prod_last=0: acc<=sum, cnt<=cnt+1 (saturating), ovf<=ovf|ovf_step.
- Accept with prod_last=1:
  - Output regs load acc_out<=sum, term_count<=cnt+1 (saturating), overflow<=ovf|ovf_step.
  - out_valid<=1; acc, cnt and ovf clear to 0.
  - Latency: the result is visible the cycle after the last term is accepted.
- Take with no accept of a last term: out_valid<=0. Output data regs keep their values, but are don't-care while out_valid=0.
- Take and accept of a last term in the same cycle: the new result loads and out_valid stays 1. This sustains one group per cycle for 1-term groups.
- While out_valid=1 and out_ready=0:
  - in_ready=0, so no product is accepted.
  - acc_out, term_count and overflow are held stable.
- en=0: in_ready=0; no state changes; out_valid and data are held; out_ready is ignored.
- A single-term group (prod_last on the first term) yields acc_out=ext(prod_in), term_count=1.
- prod_valid=0 cycles inside a group are bubbles; the group continues across them.

Test Plan:
- Reset for 2 cycles with reset=0 -> out_valid=0, acc_out=0, term_count=0, overflow=0, in_ready=0 during reset; in_ready=1 once reset=1 and en=1.
- Products -35, 6, 48 (last on 48), out_ready=1 -> one cycle after 48: out_valid=1, acc_out=19, term_count=3, overflow=0; next cycle out_valid=0.
- Group -45, 0, 10 (last) with out_ready=0 for 3 cycles -> acc_out=-35 and term_count=3 held; in_ready=0; a product driven meanwhile is not absorbed; after out_ready=1 it is accepted on the next cycle.
- Back-to-back single-term groups 24, 7, -1 with out_ready=1 and prod_valid every cycle -> out_valid continuously 1; acc_out sequence 24, 7, -1; term_count=1 each.
- Two products 2^63-1 (ACC_W=64 build) -> overflow=1 on the result and acc_out wraps to -2; the following group of 5 reports overflow=0.
- Reset asserted mid-group after terms 5, 5 (with en=0 for one prior cycle, which holds state) -> a next group of 3 (last) yields acc_out=3, term_count=1.
